// File: rtl/rs_alu_issue_ctrl_pkg.sv
// Shared sizing, FU encoding and entry layout for the ALU reservation station.
package rs_alu_issue_ctrl_pkg;

    localparam int unsigned RS_ENTRIES = 8;
    localparam int unsigned RS_IDX_W   = 3;
    localparam int unsigned RS_AGE_W   = 6;
    localparam int unsigned TAG_W      = 5;

    localparam logic FU_ALU0 = 1'b0;
    localparam logic FU_ALU1 = 1'b1;

    typedef logic [RS_AGE_W-1:0] age_t;
    typedef logic [TAG_W-1:0]    tag_t;

    typedef struct packed {
        logic fu;
        tag_t src1;
        logic src1_rdy;
        tag_t src2;
        logic src2_rdy;
        tag_t dest;
        logic dstval;
    } entry_t;

    // True when any of the three wakeup broadcasts carries this tag.
    function automatic logic tag_hit(input tag_t tag,
                                     input logic v0, input tag_t t0,
                                     input logic v1, input tag_t t1,
                                     input logic v2, input tag_t t2);
        return (v0 && t0 == tag) || (v1 && t1 == tag) || (v2 && t2 == tag);
    endfunction

    function automatic age_t age_sat_inc(input age_t age);
        return (age == '1) ? age : age + age_t'(1);
    endfunction

endpackage

// File: rtl/rs_alu_issue_ctrl_age_select.sv
// Oldest-ready picker for one ALU port: maximum age wins, ties go to the lowest index.
module rs_alu_issue_ctrl_age_select
    import rs_alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned Entries = RS_ENTRIES,
    parameter int unsigned IdxW    = RS_IDX_W
) (
    input  logic [Entries-1:0]             cand_i,
    input  logic [Entries-1:0][RS_AGE_W-1:0] age_i,
    output logic                           valid_o,
    output logic [IdxW-1:0]                idx_o
);

    age_t best_age;

    // Strict '>' keeps the earlier (lower) index on equal ages.
    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        best_age = '0;
        for (int i = 0; i < int'(Entries); i++) begin
            if (cand_i[i] && (!valid_o || age_i[i] > best_age)) begin
                valid_o  = 1'b1;
                idx_o    = IdxW'(i);
                best_age = age_i[i];
            end
        end
    end

endmodule

// File: rtl/rs_alu_issue_ctrl.sv
// 8-entry ALU reservation station controller: allocate, wakeup CAM, dual-port
// oldest-ready select, tag broadcast and occupancy tracking.
module rs_alu_issue_ctrl
    import rs_alu_issue_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                disp_valid,
    output logic                disp_ready,
    input  logic                disp_fu,
    input  logic [TAG_W-1:0]    disp_src1,
    input  logic                disp_src1_rdy,
    input  logic [TAG_W-1:0]    disp_src2,
    input  logic                disp_src2_rdy,
    input  logic [TAG_W-1:0]    disp_dest,
    input  logic                disp_dstval,
    output logic [RS_IDX_W-1:0] disp_idx,
    input  logic                ext_wk_valid,
    input  logic [TAG_W-1:0]    ext_wk_tag,
    input  logic                iss0_ready,
    output logic                iss0_valid,
    output logic [RS_IDX_W-1:0] iss0_idx,
    input  logic                iss1_ready,
    output logic                iss1_valid,
    output logic [RS_IDX_W-1:0] iss1_idx,
    output logic                wk0_valid,
    output logic [TAG_W-1:0]    wk0_tag,
    output logic                wk1_valid,
    output logic [TAG_W-1:0]    wk1_tag,
    output logic [RS_IDX_W:0]   occupancy
);

    logic [RS_ENTRIES-1:0] valid_q, valid_d;
    entry_t                ent_q [RS_ENTRIES];
    entry_t                ent_d [RS_ENTRIES];
    age_t                  age_q [RS_ENTRIES];
    age_t                  age_d [RS_ENTRIES];
    logic [RS_IDX_W:0]     occ_q, occ_d;

    logic [RS_ENTRIES-1:0]               cand0, cand1;
    logic [RS_ENTRIES-1:0][RS_AGE_W-1:0] age_vec;
    logic                                sel0_any, sel1_any;
    logic [RS_IDX_W-1:0]                 sel0_idx, sel1_idx;
    logic                                disp_accept;

    always_comb begin
        disp_ready = ~&valid_q;
        disp_idx   = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) disp_idx = RS_IDX_W'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            cand0[i]   = valid_q[i] & ent_q[i].src1_rdy & ent_q[i].src2_rdy &
                         (ent_q[i].fu == FU_ALU0);
            cand1[i]   = valid_q[i] & ent_q[i].src1_rdy & ent_q[i].src2_rdy &
                         (ent_q[i].fu == FU_ALU1);
            age_vec[i] = age_q[i];
        end
    end

    rs_alu_issue_ctrl_age_select #(
        .Entries (RS_ENTRIES),
        .IdxW    (RS_IDX_W)
    ) u_sel0 (
        .cand_i  (cand0),
        .age_i   (age_vec),
        .valid_o (sel0_any),
        .idx_o   (sel0_idx)
    );

    rs_alu_issue_ctrl_age_select #(
        .Entries (RS_ENTRIES),
        .IdxW    (RS_IDX_W)
    ) u_sel1 (
        .cand_i  (cand1),
        .age_i   (age_vec),
        .valid_o (sel1_any),
        .idx_o   (sel1_idx)
    );

    always_comb begin
        iss0_valid = sel0_any & iss0_ready & ~flush;
        iss1_valid = sel1_any & iss1_ready & ~flush;
        iss0_idx   = iss0_valid ? sel0_idx : '0;
        iss1_idx   = iss1_valid ? sel1_idx : '0;
        wk0_valid  = iss0_valid & ent_q[sel0_idx].dstval;
        wk1_valid  = iss1_valid & ent_q[sel1_idx].dstval;
        wk0_tag    = wk0_valid ? ent_q[sel0_idx].dest : '0;
        wk1_tag    = wk1_valid ? ent_q[sel1_idx].dest : '0;
        occupancy  = occ_q;
    end

    assign disp_accept = disp_valid & disp_ready & ~flush;

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
            age_d[i] = age_q[i];
            if (valid_q[i]) begin
                if (tag_hit(ent_q[i].src1, wk0_valid, wk0_tag, wk1_valid, wk1_tag,
                            ext_wk_valid, ext_wk_tag)) ent_d[i].src1_rdy = 1'b1;
                if (tag_hit(ent_q[i].src2, wk0_valid, wk0_tag, wk1_valid, wk1_tag,
                            ext_wk_valid, ext_wk_tag)) ent_d[i].src2_rdy = 1'b1;
                age_d[i] = age_sat_inc(age_q[i]);
            end
        end
        if (iss0_valid) valid_d[sel0_idx] = 1'b0;
        if (iss1_valid) valid_d[sel1_idx] = 1'b0;
        // Sources produced by a same-cycle grant or external wakeup arrive already ready.
        if (disp_accept) begin
            valid_d[disp_idx] = 1'b1;
            age_d[disp_idx]   = '0;
            ent_d[disp_idx]   = '{
                fu:       disp_fu,
                src1:     disp_src1,
                src1_rdy: disp_src1_rdy | tag_hit(disp_src1, wk0_valid, wk0_tag, wk1_valid,
                                                  wk1_tag, ext_wk_valid, ext_wk_tag),
                src2:     disp_src2,
                src2_rdy: disp_src2_rdy | tag_hit(disp_src2, wk0_valid, wk0_tag, wk1_valid,
                                                  wk1_tag, ext_wk_valid, ext_wk_tag),
                dest:     disp_dest,
                dstval:   disp_dstval
            };
        end
        if (flush) valid_d = '0;
    end

    always_comb begin
        occ_d = occ_q + {{RS_IDX_W{1'b0}}, disp_accept}
                      - {{RS_IDX_W{1'b0}}, iss0_valid}
                      - {{RS_IDX_W{1'b0}}, iss1_valid};
        if (flush) occ_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                ent_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule
